ps2_key_event_decoder: RTL and testbench

//  Next-generation PS/2 keyboard scan-code decoder (Set 2). Sits between ps2_controller and user logic.

---
 rtl/ps2_key_event_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set 2 scan-code decoder. It turns E0/F0/E1 prefixed byte sequences into single key
// events, can optionally drop typematic repeats using a small held-key table, and buffers the
// events in a first-word-fall-through FIFO that the consumer drains with a valid/ready handshake.
//
// Ports:
//   clk, reset         system clock, asynchronous active-low reset
//   data, data_ready   received byte and its 1-cycle strobe
//   ev_code/ev_ext/ev_break/ev_valid, ev_ready   event FIFO head and handshake
//   fifo_level         number of events stored
//   keys_held, any_key number of occupied held-table slots, and whether it is non-zero
//   overflow           sticky flag: an event was dropped because the FIFO was full
//   clr_overflow       synchronous clear of overflow (a set in the same cycle wins)
module ps2_key_event_decoder #(
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned HELD_SLOTS      = 6,
   parameter int unsigned SUPPRESS_REPEAT = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [7:0]                      data,
   input  logic                            data_ready,
   output logic [7:0]                      ev_code,
   output logic                            ev_ext,
   output logic                            ev_break,
   output logic                            ev_valid,
   input  logic                            ev_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [$clog2(HELD_SLOTS+1)-1:0] keys_held,
   output logic                            any_key,
   output logic                            overflow,
   input  logic                            clr_overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned KW = $clog2(HELD_SLOTS + 1);
   localparam logic [AW:0] DepthLvl = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

   state_e      state_q, state_d;
   logic [2:0]  skip_q, skip_d;
   logic        pend_valid_q, pend_valid_d;
   logic [7:0]  pend_code_q, pend_code_d;
   logic        pend_ext_q, pend_ext_d;
   logic        pend_brk_q, pend_brk_d;

   logic [HELD_SLOTS-1:0] slot_valid_q, slot_valid_d;
   logic [8:0]            slot_key_q [HELD_SLOTS];
   logic [8:0]            slot_key_d [HELD_SLOTS];

   logic [9:0]  mem_q [FIFO_DEPTH];
   logic [9:0]  mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          overflow_q, overflow_d;

   logic dec_emit, dec_ext, dec_brk, dec_pause;
   logic [8:0] key;
   logic [HELD_SLOTS-1:0] match, ins_oh;
   logic ins_found;
   logic [KW-1:0] held_cnt;
   logic push, pop, full, drop;

   // Byte-level sequence decoder
   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      dec_emit  = 1'b0;
      dec_ext   = 1'b0;
      dec_brk   = 1'b0;
      dec_pause = 1'b0;
      if (data_ready) begin
         unique case (state_q)
            StIdle: begin
               case (data)
                  8'hE0: state_d = StExt;
                  8'hF0: state_d = StBrk;
                  8'hE1: begin
                     state_d   = StPause;
                     skip_d    = 3'd7;
                     dec_emit  = 1'b1;
                     dec_pause = 1'b1;
                  end
                  8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                  default: dec_emit = 1'b1;
               endcase
            end
            StExt: begin
               case (data)
                  8'hF0:        state_d = StExtBrk;
                  8'hE0, 8'hE1: state_d = StIdle;
                  default: begin
                     state_d  = StIdle;
                     dec_emit = 1'b1;
                     dec_ext  = 1'b1;
                  end
               endcase
            end
            StBrk, StExtBrk: begin
               state_d = StIdle;
               if (data != 8'hF0 && data != 8'hE0) begin
                  dec_emit = 1'b1;
                  dec_brk  = 1'b1;
                  dec_ext  = (state_q == StExtBrk);
               end
            end
            StPause: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Held-key table lookup/update and pending event register
   always_comb begin
      key          = {dec_ext, data};
      slot_valid_d = slot_valid_q;
      slot_key_d   = slot_key_q;
      pend_valid_d = 1'b0;
      pend_code_d  = data;
      pend_ext_d   = dec_ext;
      pend_brk_d   = dec_brk;
      match        = '0;
      ins_oh       = '0;
      ins_found    = 1'b0;
      for (int i = 0; i < HELD_SLOTS; i++) begin
         match[i] = slot_valid_q[i] && (slot_key_q[i] == key);
         if (!slot_valid_q[i] && !ins_found) begin
            ins_oh[i] = 1'b1;
            ins_found = 1'b1;
         end
      end
      if (dec_emit) begin
         if (dec_pause) begin
            pend_valid_d = 1'b1;
         end else if (dec_brk) begin
            pend_valid_d = 1'b1;
            slot_valid_d = slot_valid_q & ~match;
         end else if (|match) begin
            pend_valid_d = (SUPPRESS_REPEAT == 0);
         end else begin
            // Table full: ins_oh is all zero, the event still goes out
            pend_valid_d = 1'b1;
            for (int i = 0; i < HELD_SLOTS; i++) begin
               if (ins_oh[i]) begin
                  slot_valid_d[i] = 1'b1;
                  slot_key_d[i]   = key;
               end
            end
         end
      end
   end

   // Event FIFO; a full FIFO still accepts a push when the head pops in the same cycle
   always_comb begin
      full       = (level_q == DepthLvl);
      pop        = (level_q != '0) && ev_ready;
      push       = pend_valid_q && (!full || pop);
      drop       = pend_valid_q && !push;
      mem_d      = mem_q;
      if (push) mem_d[wr_ptr_q] = {pend_brk_q, pend_ext_q, pend_code_q};
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d    = level_q;
      if (push && !pop) level_d = level_q + (AW + 1)'(1);
      if (!push && pop) level_d = level_q - (AW + 1)'(1);
      overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
   end

   always_comb begin
      held_cnt = '0;
      for (int i = 0; i < HELD_SLOTS; i++) held_cnt = held_cnt + KW'(slot_valid_q[i]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         skip_q       <= 3'd0;
         pend_valid_q <= 1'b0;
         pend_code_q  <= 8'd0;
         pend_ext_q   <= 1'b0;
         pend_brk_q   <= 1'b0;
         slot_valid_q <= '0;
         for (int i = 0; i < HELD_SLOTS; i++) slot_key_q[i] <= 9'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 10'd0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         skip_q       <= skip_d;
         pend_valid_q <= pend_valid_d;
         pend_code_q  <= pend_code_d;
         pend_ext_q   <= pend_ext_d;
         pend_brk_q   <= pend_brk_d;
         slot_valid_q <= slot_valid_d;
         slot_key_q   <= slot_key_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         overflow_q   <= overflow_d;
      end
   end

   assign ev_valid   = (level_q != '0);
   assign ev_code    = mem_q[rd_ptr_q][7:0];
   assign ev_ext     = mem_q[rd_ptr_q][8];
   assign ev_break   = mem_q[rd_ptr_q][9];
   assign fifo_level = level_q;
   assign keys_held  = held_cnt;
   assign any_key    = (held_cnt != '0);
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed scenarios followed by randomized byte streams,
// compared every cycle against a behavioural model built on byte queues and a key set.
module tb_ps2_key_event_decoder;

   localparam int unsigned FifoDepth = 8;
   localparam int unsigned HeldSlots = 6;
   localparam int unsigned SuppressRepeat = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data = 8'd0;
   logic       data_ready = 1'b0;
   logic [7:0] ev_code;
   logic       ev_ext, ev_break, ev_valid;
   logic       ev_ready = 1'b0;
   logic [3:0] fifo_level;
   logic [2:0] keys_held;
   logic       any_key, overflow;
   logic       clr_overflow = 1'b0;

   ps2_key_event_decoder #(
      .FIFO_DEPTH      (FifoDepth),
      .HELD_SLOTS      (HeldSlots),
      .SUPPRESS_REPEAT (SuppressRepeat)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .data         (data),
      .data_ready   (data_ready),
      .ev_code      (ev_code),
      .ev_ext       (ev_ext),
      .ev_break     (ev_break),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .fifo_level   (fifo_level),
      .keys_held    (keys_held),
      .any_key      (any_key),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {logic [7:0] code; logic ext; logic brk;} ev_t;
   ev_t        m_q[$];
   bit         m_pend;
   ev_t        m_pend_ev;
   bit         m_ovf;
   bit         m_held[512];
   int         m_nheld;
   logic [7:0] seq[$];
   int         pause_left;

   function automatic void model_clear();
      m_q.delete();
      seq.delete();
      m_pend = 0;
      m_ovf = 0;
      m_nheld = 0;
      pause_left = 0;
      for (int i = 0; i < 512; i++) m_held[i] = 0;
   endfunction

   function automatic void post(input logic [7:0] code, input bit ext, input bit brk);
      m_pend = 1;
      m_pend_ev.code = code;
      m_pend_ev.ext = ext;
      m_pend_ev.brk = brk;
   endfunction

   function automatic void key_event(input logic [7:0] code, input bit ext, input bit brk);
      int k = {23'd0, ext, code};
      if (brk) begin
         if (m_held[k]) begin
            m_held[k] = 0;
            m_nheld--;
         end
         post(code, ext, 1'b1);
      end else if (m_held[k]) begin
         if (SuppressRepeat == 0) post(code, ext, 1'b0);
      end else begin
         post(code, ext, 1'b0);
         if (m_nheld < HeldSlots) begin
            m_held[k] = 1;
            m_nheld++;
         end
      end
   endfunction

   function automatic void interpret(input logic [7:0] b);
      bit ext, brk;
      if (pause_left > 0) begin
         pause_left--;
         return;
      end
      if (seq.size() == 0) begin
         if (b == 8'hE0 || b == 8'hF0) seq.push_back(b);
         else if (b == 8'hE1) begin
            post(8'hE1, 1'b0, 1'b0);
            pause_left = 7;
         end else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            key_event(b, 1'b0, 1'b0);
         end
         return;
      end
      ext = (seq[0] == 8'hE0);
      brk = (seq[seq.size()-1] == 8'hF0);
      if (b == 8'hF0 && ext && !brk) begin
         seq.push_back(b);
         return;
      end
      if (b != 8'hE0 && b != 8'hF0 && !(b == 8'hE1 && !brk)) key_event(b, ext, brk);
      seq.delete();
   endfunction

   function automatic void model_edge(input logic [7:0] d, input bit dr, input bit rdy,
                                      input bit clr);
      bit dropped = 0;
      if (m_q.size() != 0 && rdy) m_q.delete(0);
      if (m_pend) begin
         if (m_q.size() < FifoDepth) m_q.push_back(m_pend_ev);
         else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_pend = 0;
      if (dr) interpret(d);
   endfunction

   task automatic check_outputs();
      check_eq("ev_valid", ev_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         check_eq("ev_code", ev_code, m_q[0].code);
         check_eq("ev_ext", ev_ext, m_q[0].ext);
         check_eq("ev_break", ev_break, m_q[0].brk);
      end
      check_eq("fifo_level", fifo_level, m_q.size());
      check_eq("keys_held", keys_held, m_nheld);
      check_eq("any_key", any_key, m_nheld != 0);
      check_eq("overflow", overflow, m_ovf);
   endtask

   task automatic step(input logic [7:0] d, input bit dr, input bit rdy, input bit clr);
      @(negedge clk);
      data = d;
      data_ready = dr;
      ev_ready = rdy;
      clr_overflow = clr;
      #1;
      check_outputs();
      @(posedge clk);
      model_edge(d, dr, rdy, clr);
   endtask

   task automatic send(input logic [7:0] d, input bit rdy);
      step(d, 1'b1, rdy, 1'b0);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(8'h00, 1'b0, rdy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      data_ready = 1'b0;
      ev_ready = 1'b0;
      clr_overflow = 1'b0;
      #1;
      check_eq("rst_ev_valid", ev_valid, 0);
      check_eq("rst_ev_code", ev_code, 0);
      check_eq("rst_ev_ext", ev_ext, 0);
      check_eq("rst_ev_break", ev_break, 0);
      check_eq("rst_fifo_level", fifo_level, 0);
      check_eq("rst_keys_held", keys_held, 0);
      check_eq("rst_any_key", any_key, 0);
      check_eq("rst_overflow", overflow, 0);
      model_clear();
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [7:0] pool[10] = '{8'h1C, 8'h75, 8'h14, 8'h77, 8'h23, 8'h2B, 8'h34, 8'h4B, 8'h5A, 8'h66};
   logic [7:0] ignored[6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
   logic [7:0] makes9[9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

   initial begin
      model_clear();
      repeat (2) @(negedge clk);
      do_reset();

      // single make, FWFT latency
      send(8'h1C, 1'b1);
      idle(4, 1'b1);
      // repeats suppressed, then break
      send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
      send(8'hF0, 1'b1); send(8'h1C, 1'b1);
      idle(4, 1'b1);
      // extended make/break, and bare 75 as a distinct key
      send(8'hE0, 1'b1); send(8'h75, 1'b1);
      send(8'h75, 1'b1);
      idle(2, 1'b1);
      send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
      idle(3, 1'b1);
      // Pause sequence
      send(8'hE1, 1'b1); send(8'h14, 1'b1); send(8'h77, 1'b1); send(8'hE1, 1'b1);
      send(8'hF0, 1'b1); send(8'h14, 1'b1); send(8'hF0, 1'b1); send(8'h77, 1'b1);
      send(8'h1C, 1'b1);
      idle(4, 1'b1);

      // overflow with a stalled consumer; also fills the held table
      do_reset();
      foreach (makes9[i]) send(makes9[i], 1'b0);
      idle(3, 1'b0);
      idle(10, 1'b1);
      step(8'h00, 1'b0, 1'b1, 1'b1);
      idle(2, 1'b1);

      // reset between E0 and 75
      send(8'hE0, 1'b1);
      do_reset();
      send(8'h75, 1'b1);
      idle(4, 1'b1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] b;
         int r = $urandom_range(0, 99);
         bit stingy = ((n / 200) % 2) == 1;
         bit rdy;
         if (r < 15) b = 8'hE0;
         else if (r < 30) b = 8'hF0;
         else if (r < 33) b = 8'hE1;
         else if (r < 37) b = ignored[$urandom_range(0, 5)];
         else if (r < 85) b = pool[$urandom_range(0, 9)];
         else b = 8'($urandom_range(0, 255));
         rdy = stingy ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) != 0);
         if (n % 1000 == 999) do_reset();
         step(b, $urandom_range(0, 2) != 0, rdy, $urandom_range(0, 15) == 0);
      end
      idle(12, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
